// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port (CPU/DMA) single-RAM arbiter.
package ram_arb_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_e;

  localparam int MODE_RR    = 0;
  localparam int MODE_FIXED = 1;

endpackage

// File: rtl/arb_pick2.sv
// Combinational 2-way winner selection: round-robin or CPU-priority with a
// starvation override for DMA. reqs[0] is the CPU, reqs[1] is the DMA.
module arb_pick2
  import ram_arb_pkg::*;
(
  input  logic [1:0] reqs,
  input  owner_e     last_owner,
  input  logic       mode,
  input  logic       starve,
  output owner_e     winner
);

  // mode: 0 = round-robin, 1 = fixed CPU priority
  always_comb begin
    winner = OWN_CPU;
    case (reqs)
      2'b10: winner = OWN_DMA;
      2'b11: begin
        if (mode) begin
          winner = starve ? OWN_DMA : OWN_CPU;
        end else begin
          winner = (last_owner == OWN_CPU) ? OWN_DMA : OWN_CPU;
        end
      end
      default: winner = OWN_CPU;
    endcase
  end

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates a CPU port and a DMA port onto one combinational-read RAM,
// one access every two cycles (IDLE arbitrates, ACCESS drives the RAM).
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 4,
  parameter int MODE     = 0,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_valid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_valid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int   WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic FIXED  = (MODE == MODE_FIXED);

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  owner_e              last_owner_q, last_owner_d;
  logic                cpu_gnt_q, cpu_gnt_d, dma_gnt_q, dma_gnt_d;
  logic                ram_en_q, ram_en_d, ram_we_q, ram_we_d;
  logic                cpu_valid_q, cpu_valid_d, dma_valid_q, dma_valid_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d, dma_rdata_q, dma_rdata_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  owner_e              winner;
  logic                starve;

  function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] v);
    if (v == WAIT_W'(MAX_WAIT)) return v;
    return v + WAIT_W'(1);
  endfunction

  assign starve = (wait_cnt_q == WAIT_W'(MAX_WAIT));

  arb_pick2 u_pick (
    .reqs       ({dma_req, cpu_req}),
    .last_owner (last_owner_q),
    .mode       (FIXED),
    .starve     (starve),
    .winner     (winner)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    wait_cnt_d   = wait_cnt_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cpu_rdata_d  = cpu_rdata_q;
    dma_rdata_d  = dma_rdata_q;
    cpu_gnt_d    = 1'b0;
    dma_gnt_d    = 1'b0;
    ram_en_d     = 1'b0;
    ram_we_d     = 1'b0;
    cpu_valid_d  = 1'b0;
    dma_valid_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cpu_req || dma_req) begin
          state_d      = ST_ACCESS;
          owner_d      = winner;
          last_owner_d = winner;
          ram_en_d     = 1'b1;
          if (winner == OWN_CPU) begin
            we_d      = cpu_we;
            addr_d    = cpu_addr;
            wdata_d   = cpu_wdata;
            cpu_gnt_d = 1'b1;
            ram_we_d  = cpu_we;
          end else begin
            we_d      = dma_we;
            addr_d    = dma_addr;
            wdata_d   = dma_wdata;
            dma_gnt_d = 1'b1;
            ram_we_d  = dma_we;
          end
        end
        // Starvation guard only counts CPU wins taken while DMA is waiting.
        if (FIXED) begin
          if (!dma_req || winner == OWN_DMA) wait_cnt_d = '0;
          else                               wait_cnt_d = sat_inc(wait_cnt_q);
        end
      end
      ST_ACCESS: begin
        state_d = ST_IDLE;
        if (owner_q == OWN_CPU) begin
          cpu_valid_d = 1'b1;
          if (!we_q) cpu_rdata_d = ram_rdata;
        end else begin
          dma_valid_d = 1'b1;
          if (!we_q) dma_rdata_d = ram_rdata;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and visible outputs: cleared asynchronously so a reset mid-ACCESS
  // drops ram_en/ram_we at once and suppresses the pending valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_DMA;
      last_owner_q <= OWN_DMA;
      wait_cnt_q   <= '0;
      cpu_gnt_q    <= 1'b0;
      dma_gnt_q    <= 1'b0;
      ram_en_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      cpu_valid_q  <= 1'b0;
      dma_valid_q  <= 1'b0;
      cpu_rdata_q  <= '0;
      dma_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      wait_cnt_q   <= wait_cnt_d;
      cpu_gnt_q    <= cpu_gnt_d;
      dma_gnt_q    <= dma_gnt_d;
      ram_en_q     <= ram_en_d;
      ram_we_q     <= ram_we_d;
      cpu_valid_q  <= cpu_valid_d;
      dma_valid_q  <= dma_valid_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dma_rdata_q  <= dma_rdata_d;
    end
  end

  // Latched command: only observed while ram_en is high.
  always_ff @(posedge clk) begin
    we_q    <= we_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  assign cpu_gnt   = cpu_gnt_q;
  assign dma_gnt   = dma_gnt_q;
  assign cpu_valid = cpu_valid_q;
  assign dma_valid = dma_valid_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;
  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;

endmodule
